// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL lock qualifier and sequenced system reset generator
module pll_reset_sequencer #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int LOSS_W             = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pll_locked,
    input  logic              soft_reset_req,
    output logic              sys_reset_n,
    output logic              lock_stable,
    output logic [1:0]        seq_state,
    output logic [LOSS_W-1:0] lock_loss_count
);

    localparam int SCW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int HCW = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam logic [SCW-1:0]    STABLE_LAST = SCW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HCW-1:0]    HOLD_LAST   = HCW'(RESET_HOLD_CYCLES - 1);
    localparam logic [LOSS_W-1:0] LOSS_MAX    = '1;

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_STABLE    = 2'd1,
        S_HOLD      = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [SCW-1:0]         stable_cnt_q, stable_cnt_d;
    logic [HCW-1:0]         hold_cnt_q, hold_cnt_d;
    logic [LOSS_W-1:0]      loss_cnt_q, loss_cnt_d;
    logic                   sys_reset_n_q, sys_reset_n_d;
    logic                   lock_stable_q, lock_stable_d;
    logic                   locked_s;
    logic                   lost;

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], pll_locked};
        state_d      = state_q;
        stable_cnt_d = stable_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        loss_cnt_d   = loss_cnt_q;
        lost         = 1'b0;

        case (state_q)
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_d      = S_STABLE;
                    stable_cnt_d = '0;
                end
            end
            S_STABLE: begin
                // A drop before qualification completes is a glitch, not a counted loss
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                end else if (stable_cnt_q == STABLE_LAST) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                end else begin
                    stable_cnt_d = stable_cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                    lost    = 1'b1;
                end else if (soft_reset_req) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                    lost    = 1'b1;
                end else if (soft_reset_req) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                end
            end
            default: state_d = S_WAIT_LOCK;
        endcase

        if (lost && (loss_cnt_q != LOSS_MAX)) begin
            loss_cnt_d = loss_cnt_q + 1'b1;
        end

        // Outputs follow the next state so reset release lines up with entering RUN
        sys_reset_n_d = (state_d == S_RUN);
        lock_stable_d = (state_d == S_HOLD) || (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q        <= '0;
            state_q       <= S_WAIT_LOCK;
            stable_cnt_q  <= '0;
            hold_cnt_q    <= '0;
            loss_cnt_q    <= '0;
            sys_reset_n_q <= 1'b0;
            lock_stable_q <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            state_q       <= state_d;
            stable_cnt_q  <= stable_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            loss_cnt_q    <= loss_cnt_d;
            sys_reset_n_q <= sys_reset_n_d;
            lock_stable_q <= lock_stable_d;
        end
    end

    assign sys_reset_n     = sys_reset_n_q;
    assign lock_stable     = lock_stable_q;
    assign seq_state       = state_q;
    assign lock_loss_count = loss_cnt_q;

endmodule
